dmm_key_ctrl: RTL
=================

# dmm_key_ctrl

Front-panel key controller for the multimeter. Consumes the N debounced key levels from the per-key debouncer instances, supplies their rise/fall debounce constants, and arbitrates among the keys so one key at a time is serviced. Classifies each press as short, long or auto-repeat, and sequences the measurement configuration registers (mode, range, hold) consumed by the measurement and display blocks.

## Interface
- N_KEY, 4: number of keys, 4..8; keys 0..3 have fixed actions.
- CNT_W, 4: debounce counter width, matching the debouncer.
- DEB_RISE, 10: rise debounce count driven to the debouncers.
- DEB_FALL, 10: fall debounce count driven to the debouncers.
- TICK_DIV, 100000: clk cycles per timing tick (1 ms at 100 MHz), ≥2.
- LONG_T, 1000: ticks of continuous press before a long event, ≥2.
- REP_T, 200: ticks between repeat events after a long event, ≥2.
- N_MODE, 4: number of measurement modes, ≥2.
- N_RANGE, 4: number of ranges, ≥2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- key_i  in  N_KEY  debounced key levels, 1 = pressed.
- deb_rise_o  out  CNT_W  constant DEB_RISE.
- deb_fall_o  out  CNT_W  constant DEB_FALL.
- evt_valid_o  out  1  one-cycle key event strobe.
- evt_key_o  out  $clog2(N_KEY)  key index of the event.
- evt_type_o  out  2  event type: 0 = SHORT, 1 = LONG, 2 = REPEAT.
- mode_o  out  $clog2(N_MODE)  measurement mode.
- range_o  out  $clog2(N_RANGE)  range select.
- hold_o  out  1  display hold.

## Operation
- Tick prescaler: free-running 0..TICK_DIV-1 from reset. tick = 1 for one cycle when the count equals TICK_DIV-1, then the count wraps to 0.
- Hold counter: counts ticks, width $clog2(max(LONG_T,REP_T)). Cleared on every state entry and on every LONG or REPEAT event.
- Key selection: sel = lowest set index of key_i, latched on exit from IDLE.
- FSM states: IDLE, PRESS, HELD, WAIT_REL. Reset state is IDLE.
  - IDLE: if key_i != 0, latch sel and go to PRESS.
  - PRESS:
    - key_i[sel]==0: emit SHORT and go to WAIT_REL.
    - Else, tick with hold_cnt==LONG_T-1: emit LONG and go to HELD.
    - Else, tick: hold_cnt++.
  - HELD:
    - key_i[sel]==0: go to WAIT_REL with no event.
    - Else, tick with hold_cnt==REP_T-1: emit REPEAT and clear hold_cnt.
    - Else, tick: hold_cnt++.
  - WAIT_REL: go to IDLE when key_i == 0 (all keys released).
- Simultaneous press: the lowest index wins. Any key that is not selected is ignored until all keys are released.
- Release and tick in the same cycle: release wins, so SHORT is emitted in PRESS and no event in HELD.
- Actions, applied in the same registered update as the event:
  - key0 SHORT: mode = (mode==N_MODE-1) ? 0 : mode+1; range = 0.
  - key0 LONG: mode = 0, range = 0, hold = 0.
  - key1 SHORT/REPEAT: range increments, wrapping N_RANGE-1 → 0.
  - key3 SHORT/REPEAT: range decrements, wrapping 0 → N_RANGE-1.
  - key2 SHORT: hold toggles.
  - All other key/type combinations: event is emitted only, no action.
- Reset values: evt_valid_o = 0, evt_key_o = 0, evt_type_o = 0, mode_o = 0, range_o = 0, hold_o = 0, prescaler = 0, hold_cnt = 0.
- Reset asserted mid-operation returns everything to reset values immediately. After release, a key still held is treated as a new press.

## Timing
- All outputs except the deb_* constants are registered.
- Latency:
  - Press at input (cycle t) → state = PRESS at t+1.
  - Release seen in PRESS (cycle t) → evt_valid_o = 1 and updated mode/range/hold at t+1.
  - The LONG and REPEAT events follow the same one-cycle latency from the qualifying tick.
- evt_valid_o lasts exactly one cycle. evt_key_o and evt_type_o are valid only while evt_valid_o = 1.
- LONG fires LONG_T ticks after PRESS entry, with a tick-phase jitter of less than 1 tick. Each REPEAT fires REP_T ticks after the previous LONG or REPEAT.
- At most one event per cycle.

## Test plan
Bench parameters: TICK_DIV = 4, LONG_T = 5, REP_T = 3, N_MODE = 4, N_RANGE = 4.

1. Reset, then key_i = 0001 for 8 cycles, then 0:
   - Required: one SHORT event with key = 0; mode_o 0 → 1; range_o = 0.
2. key_i = 0010 held for 40 cycles:
   - Required: LONG with key = 1, then a REPEAT every 12 cycles.
   - Required: range_o increments on each REPEAT only, wrapping 3 → 0.
   - Required: no event on release.
3. key_i = 0101 applied in the same cycle, then key0 released while key2 stays held:
   - Required: SHORT with key = 0 only; hold_o unchanged.
   - Required: no IDLE until key2 releases.
4. key3 SHORT with range_o = 0:
   - Required: range_o = 3. Two key2 SHORTs toggle hold_o 0 → 1 → 0.
5. mode_o = 3, then key0 SHORT → mode_o = 0. Then key0 long press → LONG event; mode_o, range_o and hold_o all 0.
6. rst_n pulsed low while in HELD with key_i = 0001 still high:
   - Required: all outputs 0 during reset.
   - Required: after release of reset, a new PRESS starts, and LONG arrives a full LONG_T ticks later.

Source files
------------

// File: rtl/dmm_key_ctrl.sv
// Front-panel key controller: one-at-a-time key arbitration, short/long/repeat
// press classification and the mode/range/hold configuration registers.
module dmm_key_ctrl #(
  parameter int N_KEY    = 4,
  parameter int CNT_W    = 4,
  parameter int DEB_RISE = 10,
  parameter int DEB_FALL = 10,
  parameter int TICK_DIV = 100000,
  parameter int LONG_T   = 1000,
  parameter int REP_T    = 200,
  parameter int N_MODE   = 4,
  parameter int N_RANGE  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_KEY-1:0]           key_i,
  output logic [CNT_W-1:0]           deb_rise_o,
  output logic [CNT_W-1:0]           deb_fall_o,
  output logic                       evt_valid_o,
  output logic [$clog2(N_KEY)-1:0]   evt_key_o,
  output logic [1:0]                 evt_type_o,
  output logic [$clog2(N_MODE)-1:0]  mode_o,
  output logic [$clog2(N_RANGE)-1:0] range_o,
  output logic                       hold_o
);

  localparam int KEY_W    = $clog2(N_KEY);
  localparam int MODE_W   = $clog2(N_MODE);
  localparam int RANGE_W  = $clog2(N_RANGE);
  localparam int PRE_W    = $clog2(TICK_DIV);
  localparam int HOLD_MAX = (LONG_T > REP_T) ? LONG_T : REP_T;
  localparam int HOLD_W   = $clog2(HOLD_MAX);

  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0]  LONG_LAST  = HOLD_W'(LONG_T - 1);
  localparam logic [HOLD_W-1:0]  REP_LAST   = HOLD_W'(REP_T - 1);
  localparam logic [MODE_W-1:0]  MODE_LAST  = MODE_W'(N_MODE - 1);
  localparam logic [RANGE_W-1:0] RANGE_LAST = RANGE_W'(N_RANGE - 1);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, WAIT_REL} state_t;
  typedef enum logic [1:0] {EVT_SHORT = 2'd0, EVT_LONG = 2'd1, EVT_REPEAT = 2'd2} evt_t;

  state_t              state_reg;
  logic [PRE_W-1:0]    presc_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic [KEY_W-1:0]    sel_reg;
  logic [KEY_W-1:0]    low_idx;
  logic                tick;
  logic                key_sel;
  logic                fire;
  evt_t                fire_type;

  assign deb_rise_o = CNT_W'(DEB_RISE);
  assign deb_fall_o = CNT_W'(DEB_FALL);

  assign tick    = (presc_reg == PRE_LAST);
  assign key_sel = key_i[sel_reg];

  // Scan from the top so the lowest pressed index is the last one written.
  always_comb begin
    low_idx = '0;
    for (int i = N_KEY - 1; i >= 0; i--) begin
      if (key_i[i]) low_idx = KEY_W'(i);
    end
  end

  // Event decode; a release always beats a coincident tick.
  always_comb begin
    fire      = 1'b0;
    fire_type = EVT_SHORT;
    case (state_reg)
      PRESS: begin
        if (!key_sel) begin
          fire      = 1'b1;
          fire_type = EVT_SHORT;
        end else if (tick && hold_cnt_reg == LONG_LAST) begin
          fire      = 1'b1;
          fire_type = EVT_LONG;
        end
      end
      HELD: begin
        if (key_sel && tick && hold_cnt_reg == REP_LAST) begin
          fire      = 1'b1;
          fire_type = EVT_REPEAT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      presc_reg    <= '0;
      hold_cnt_reg <= '0;
      sel_reg      <= '0;
      evt_valid_o  <= 1'b0;
      evt_key_o    <= '0;
      evt_type_o   <= '0;
      mode_o       <= '0;
      range_o      <= '0;
      hold_o       <= 1'b0;
    end else begin
      presc_reg   <= tick ? '0 : presc_reg + PRE_W'(1);
      evt_valid_o <= fire;
      if (fire) begin
        evt_key_o  <= sel_reg;
        evt_type_o <= fire_type;
      end

      case (state_reg)
        IDLE: begin
          if (key_i != '0) begin
            sel_reg      <= low_idx;
            hold_cnt_reg <= '0;
            state_reg    <= PRESS;
          end
        end
        PRESS: begin
          if (!key_sel) begin
            hold_cnt_reg <= '0;
            state_reg    <= WAIT_REL;
          end else if (fire) begin
            hold_cnt_reg <= '0;
            state_reg    <= HELD;
          end else if (tick) begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
          end
        end
        HELD: begin
          if (!key_sel) begin
            hold_cnt_reg <= '0;
            state_reg    <= WAIT_REL;
          end else if (fire) begin
            hold_cnt_reg <= '0;
          end else if (tick) begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
          end
        end
        default: begin
          // Unselected keys stay ignored until the whole panel is released.
          if (key_i == '0) begin
            hold_cnt_reg <= '0;
            state_reg    <= IDLE;
          end
        end
      endcase

      if (fire) begin
        if (sel_reg == KEY_W'(0)) begin
          if (fire_type == EVT_SHORT) begin
            mode_o  <= (mode_o == MODE_LAST) ? '0 : mode_o + MODE_W'(1);
            range_o <= '0;
          end else if (fire_type == EVT_LONG) begin
            mode_o  <= '0;
            range_o <= '0;
            hold_o  <= 1'b0;
          end
        end else if (sel_reg == KEY_W'(1)) begin
          if (fire_type != EVT_LONG)
            range_o <= (range_o == RANGE_LAST) ? '0 : range_o + RANGE_W'(1);
        end else if (sel_reg == KEY_W'(2)) begin
          if (fire_type == EVT_SHORT) hold_o <= ~hold_o;
        end else if (sel_reg == KEY_W'(3)) begin
          if (fire_type != EVT_LONG)
            range_o <= (range_o == '0) ? RANGE_LAST : range_o - RANGE_W'(1);
        end
      end
    end
  end

endmodule
